// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared PHT constants, counter encodings and saturating update
package bp_pkg;

   localparam int IDX_WIDTH = 7;
   localparam int ENTRIES   = 1 << IDX_WIDTH;

   localparam logic [1:0] SN = 2'b00;
   localparam logic [1:0] WN = 2'b01;
   localparam logic [1:0] WT = 2'b10;
   localparam logic [1:0] ST = 2'b11;

   typedef enum logic {INIT, RUN} bp_state_e;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic dir);
      logic [1:0] res;
      if (dir) res = (ctr == ST) ? ST : ctr + 2'b01;
      else     res = (ctr == SN) ? SN : ctr - 2'b01;
      return res;
   endfunction

endpackage

// File: rtl/bp_train_fifo.sv
// rtl/bp_train_fifo.sv - synchronous training-record FIFO with flush and registered full
module bp_train_fifo
   import bp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = full_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full_q;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
         endcase
      end
      full_d = (count_d == (PW+1)'(DEPTH));
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // Storage needs no reset: entries are only read once the count says they were written.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - PHT write-port scheduler: init/clear sweep, then serialised RMW training
module bp_update_ctrl
   import bp_pkg::*;
#(
   parameter int IDX_WIDTH  = 7,
   parameter int ENTRIES    = 128,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [IDX_WIDTH-1:0] req_idx_i,
   input  logic                 req_dir_i,
   output logic [IDX_WIDTH-1:0] pht_ridx_o,
   input  logic [1:0]           pht_rdata_i,
   output logic                 pht_we_o,
   output logic [IDX_WIDTH-1:0] pht_widx_o,
   output logic [1:0]           pht_wdata_o,
   output logic                 init_busy_o
);

   bp_state_e            state_q, state_d;
   logic [IDX_WIDTH:0]   sweep_q, sweep_d;
   logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [IDX_WIDTH:0]   fifo_head;
   logic [IDX_WIDTH-1:0] head_idx;
   logic                 head_dir;
   logic                 we;

   assign head_idx    = fifo_head[IDX_WIDTH-1:0];
   assign head_dir    = fifo_head[IDX_WIDTH];
   assign req_ready_o = ~fifo_full & ~clr_i & ~rst;
   assign fifo_push   = req_valid_i & req_ready_o;
   assign pht_ridx_o  = head_idx;
   assign pht_we_o    = we & ~rst;
   assign init_busy_o = (state_q == INIT) | rst;

   bp_train_fifo #(
      .WIDTH (IDX_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i (clk_i),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (clr_i),
      .din   ({req_dir_i, req_idx_i}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      fifo_pop    = 1'b0;
      we          = 1'b0;
      pht_widx_o  = head_idx;
      pht_wdata_o = sat_update(pht_rdata_i, head_dir);
      case (state_q)
         INIT: begin
            we          = 1'b1;
            pht_widx_o  = sweep_q[IDX_WIDTH-1:0];
            pht_wdata_o = WN;
            sweep_d     = sweep_q + (IDX_WIDTH+1)'(1);
            if (sweep_q == (IDX_WIDTH+1)'(ENTRIES - 1)) state_d = RUN;
         end
         RUN: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               we       = 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
      // The write of this cycle still lands; only the next state is overridden.
      if (clr_i) begin
         state_d = INIT;
         sweep_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q <= INIT;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb/tb_bp_update_ctrl.sv - directed and randomized bench for bp_update_ctrl with a queue-based reference model
module tb_bp_update_ctrl;

   localparam int N = 128;
   localparam int D = 4;

   logic       clk_i = 1'b0;
   logic       rst;
   logic       clr_i;
   logic       req_valid_i;
   logic       req_ready_o;
   logic [6:0] req_idx_i;
   logic       req_dir_i;
   logic [6:0] pht_ridx_o;
   logic [1:0] pht_rdata_i;
   logic       pht_we_o;
   logic [6:0] pht_widx_o;
   logic [1:0] pht_wdata_o;
   logic       init_busy_o;

   logic [1:0] pht_mem [N];
   assign pht_rdata_i = pht_mem[pht_ridx_o];

   always #5 clk_i = ~clk_i;

   bp_update_ctrl #(.IDX_WIDTH(7), .ENTRIES(N), .FIFO_DEPTH(D)) dut (
      .clk_i       (clk_i),
      .rst         (rst),
      .clr_i       (clr_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_idx_i   (req_idx_i),
      .req_dir_i   (req_dir_i),
      .pht_ridx_o  (pht_ridx_o),
      .pht_rdata_i (pht_rdata_i),
      .pht_we_o    (pht_we_o),
      .pht_widx_o  (pht_widx_o),
      .pht_wdata_o (pht_wdata_o),
      .init_busy_o (init_busy_o)
   );

   bit m_init;
   int m_sweep;
   int q_idx[$];
   bit q_dir[$];
   int pht_ref [N];
   int checks;
   int errors;
   int acc_cnt;
   logic busy_s;

   function automatic int sat(input int c, input bit d);
      int r;
      r = d ? c + 1 : c - 1;
      if (r > 3) r = 3;
      if (r < 0) r = 0;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [6:0] idx, input logic d, input logic c);
      bit         exp_ready;
      bit         acc;
      logic       we_s;
      logic [6:0] widx_s;
      logic [1:0] wdata_s;
      rst         = r;
      req_valid_i = v;
      req_idx_i   = idx;
      req_dir_i   = d;
      clr_i       = c;
      @(negedge clk_i);
      exp_ready = !r && !c && (q_idx.size() < D);
      chk("ready", req_ready_o, exp_ready);
      if (r) begin
         chk("rst_we", pht_we_o, 0);
         chk("rst_busy", init_busy_o, 1);
      end else if (m_init) begin
         chk("init_we", pht_we_o, 1);
         chk("init_widx", pht_widx_o, m_sweep);
         chk("init_wdata", pht_wdata_o, 1);
         chk("init_busy", init_busy_o, 1);
      end else if (q_idx.size() > 0) begin
         chk("run_we", pht_we_o, 1);
         chk("run_ridx", pht_ridx_o, q_idx[0]);
         chk("run_widx", pht_widx_o, q_idx[0]);
         chk("run_wdata", pht_wdata_o, sat(pht_ref[q_idx[0]], q_dir[0]));
         chk("run_busy", init_busy_o, 0);
      end else begin
         chk("idle_we", pht_we_o, 0);
         chk("idle_busy", init_busy_o, 0);
      end
      busy_s  = init_busy_o;
      we_s    = pht_we_o;
      widx_s  = pht_widx_o;
      wdata_s = pht_wdata_o;
      @(posedge clk_i);
      if (we_s === 1'b1) pht_mem[widx_s] = wdata_s;
      if (r) begin
         m_init  = 1;
         m_sweep = 0;
         q_idx.delete();
         q_dir.delete();
      end else begin
         acc = v && exp_ready;
         if (acc) acc_cnt++;
         if (m_init) begin
            pht_ref[m_sweep] = 1;
         end else if (q_idx.size() > 0) begin
            pht_ref[q_idx[0]] = sat(pht_ref[q_idx[0]], q_dir[0]);
            void'(q_idx.pop_front());
            void'(q_dir.pop_front());
         end
         if (c) begin
            m_init  = 1;
            m_sweep = 0;
            q_idx.delete();
            q_dir.delete();
         end else begin
            if (m_init) begin
               m_sweep++;
               if (m_sweep == N) m_init = 0;
            end
            if (acc) begin
               q_idx.push_back(int'(idx));
               q_dir.push_back(d);
            end
         end
      end
      #1;
   endtask

   initial begin
      int busy_cnt;
      int e;
      checks  = 0;
      errors  = 0;
      acc_cnt = 0;
      m_init  = 1;
      m_sweep = 0;
      for (int i = 0; i < N; i++) begin
         pht_mem[i] = 2'($urandom_range(0, 3));
         pht_ref[i] = int'(pht_mem[i]);
      end
      rst = 1'b1; clr_i = 1'b0; req_valid_i = 1'b0; req_idx_i = '0; req_dir_i = 1'b0;
      #1;

      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);

      // Sweep after reset with three records pushed at cycle 10
      for (int cyc = 0; cyc < 140; cyc++) begin
         logic [6:0] ci;
         ci = 7'(cyc);
         step(0, (cyc >= 10 && cyc < 13), ci, ci[0], 0);
      end
      for (int i = 0; i < N; i++) begin
         e = (i == 11) ? 2 : ((i == 10 || i == 12) ? 0 : 1);
         chk("sweep_mem", pht_mem[i], e);
      end

      // Saturation on idx 5
      for (int i = 0; i < 4; i++) step(0, 1, 7'd5, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      chk("sat_up", pht_mem[5], 3);
      for (int i = 0; i < 4; i++) step(0, 1, 7'd5, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      chk("sat_down", pht_mem[5], 0);

      // Full FIFO while sweeping
      step(0, 1, 7'd9, 1, 1);
      acc_cnt = 0;
      for (int i = 0; i < N; i++) step(0, 1, 7'($urandom_range(0, 127)), 1'($urandom), 0);
      chk("full_accepts", acc_cnt, 4);
      for (int i = 0; i < 10; i++) step(0, 1, 7'($urandom_range(0, 127)), 1'($urandom), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

      // Clear with three records queued at the first RUN cycle
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < N; i++) step(0, (i < 3), 7'(40 + i), 1, 0);
      step(0, 1, 7'd50, 1, 1);
      busy_cnt = 0;
      for (int i = 0; i < N + 4; i++) begin
         step(0, 0, 0, 0, 0);
         if (busy_s === 1'b1) busy_cnt++;
      end
      chk("clr_busy_len", busy_cnt, N);
      chk("clr_head_kept", pht_mem[40], 1);

      // Randomized traffic with occasional clear and reset
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 6),
              7'($urandom_range(0, 127)), 1'($urandom), ($urandom_range(0, 299) == 0));
      end
      for (int i = 0; i < 200; i++) step(0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) chk("final_mem", pht_mem[i], pht_ref[i]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Write-port scheduler for a branch-predictor pattern history table (PHT) of 2-bit saturating counters. It performs the table's power-up and clear sweep one entry per cycle, then serialises committed training records from the MD stage into read-modify-write updates. Records are buffered in a small FIFO. It sits between the MD-stage commit logic and the PHT storage of the global or local predictor. While it is sweeping, it tells fetch to ignore PHT predictions.

## Interface
Parameters:
- IDX_WIDTH, 7, PHT index width
- ENTRIES, 128, PHT entries, equal to 2**IDX_WIDTH
- FIFO_DEPTH, 4, training FIFO depth, power of two, at least 2

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous reset, active-high (already decided)
- clr_i  in  1  one-cycle request to re-initialise the table
- req_valid_i  in  1  a training record is offered
- req_ready_o  out  1  the record is accepted at this edge when valid and ready are both high
- req_idx_i  in  IDX_WIDTH  PHT index of the record (history XOR PC, computed upstream)
- req_dir_i  in  1  resolved direction: 1 means taken, 0 means not-taken
- pht_ridx_o  out  IDX_WIDTH  PHT read index; the PHT returns data combinationally
- pht_rdata_i  in  2  counter value at pht_ridx_o
- pht_we_o  out  1  PHT write enable
- pht_widx_o  out  IDX_WIDTH  PHT write index
- pht_wdata_o  out  2  PHT write data
- init_busy_o  out  1  sweep in progress; fetch forces not-taken while high

## Operation
State machine:
- States are INIT and RUN.
- Reset puts the block in INIT with sweep index 0 and the FIFO empty.
- INIT, each cycle:
  - pht_we_o=1, pht_widx_o=sweep index, pht_wdata_o=2'b01 (weakly not-taken).
  - The sweep index increments by 1.
  - After the cycle that writes ENTRIES-1, the next state is RUN.
  - No FIFO pops.
- RUN, FIFO non-empty, each cycle:
  - pht_ridx_o=head index.
  - pht_wdata_o is the saturating update of pht_rdata_i: +1 if dir is 1 (saturate at 11), −1 if dir is 0 (saturate at 00).
  - pht_we_o=1, pht_widx_o=head index, and the head is popped.
- RUN, FIFO empty: pht_we_o=0.

Handshake and FIFO:
- req_ready_o = ~full & ~clr_i.
- Push is allowed in both INIT and RUN; records received during the sweep wait in the FIFO.
- There is no bypass. A pop and a push in the same cycle are both honoured. A full FIFO with a pop does not assert ready; ready depends only on the registered full flag.
- Back-to-back updates to the same index are exact, because each write commits at the edge before the next combinational read.

Clear:
- clr_i in any state:
  - the next state is INIT with sweep index 0;
  - the FIFO is emptied;
  - any push attempted in that cycle is rejected, since ready is low.
- clr_i during INIT restarts the sweep from 0.
- A pop or write in the clr_i cycle still completes.

Widths and unused outputs:
- The sweep index is IDX_WIDTH+1 bits so that termination is detected without wrap.
- pht_ridx_o is don't-care when no pop is occurring; the implementation drives it to the head index.

## Timing
- During rst high: pht_we_o=0, init_busy_o=1, req_ready_o=0.
- First cycle after rst is released:
  - pht_we_o=1, pht_widx_o=0, pht_wdata_o=01, init_busy_o=1.
  - req_ready_o=1, since the FIFO is empty.
- init_busy_o stays high for exactly ENTRIES cycles after reset release, or after the cycle following clr_i. It is low from the first RUN cycle.
- Latency in RUN with an empty FIFO:
  - A record accepted at edge N is written at edge N+1.
  - Fetch sees the new counter in the cycle after edge N+1.
- Throughput is one update per cycle. FIFO occupancy is bounded by FIFO_DEPTH, and the full flag is registered.
- Reset during any operation is equivalent to power-up reset.

## Structure
- Shared package bp_pkg holds:
  - IDX_WIDTH and ENTRIES;
  - the counter encodings SN=2'b00, WN=2'b01, WT=2'b10, ST=2'b11;
  - the saturating-update function;
  - the state enum {INIT, RUN}.
  The global and local predictors reuse these constants.
- The single sub-module bp_train_fifo is a synchronous FIFO with the ports push, pop, flush, full, empty and head, and a data width of IDX_WIDTH+1.

## Test plan
- Reset release:
  - Required: pht_we_o high for 128 consecutive cycles with widx 0..127, each write data 01, then init_busy_o falls.
  - PHT model: all 128 entries equal 01.
- Push during INIT:
  - Stimulus: push 3 records at cycle 10.
  - Required: req_ready_o stays 1. Writes for the records begin at cycle 128 in order, one per cycle, with data computed from the swept value 01.
- Saturation in RUN:
  - Stimulus: 4 pushes of idx 5 with dir 1, back to back.
  - Required: idx 5 sequence 01→10→11→11. Then 4 pushes with dir 0 give 10→01→00→00.
- Full FIFO:
  - Stimulus: during INIT, hold req_valid_i high.
  - Required: exactly 4 records accepted, then req_ready_o=0 until the first RUN pop. One record is accepted per cycle thereafter.
- Clear mid-stream:
  - Stimulus: in RUN with 3 records queued, pulse clr_i.
  - Required: the head write in that cycle completes. The remaining 2 records are discarded. The next cycle writes idx 0 with 01, and init_busy_o is high for 128 cycles.
